// File: rtl/rgb_de_capture.sv
// DE-only RGB565 capture: locks onto vertical blanking, emits pixels with x/y coordinates, measures frame geometry.
// Optional CAP_GEOM_CHECK_EN: flags frames whose geometry differs from H_DISP x V_DISP and drops out-of-range pixels.
module rgb_de_capture #(
  parameter logic [10:0] H_DISP   = 11'd800,
  parameter logic [10:0] V_DISP   = 11'd480,
  parameter logic [10:0] VGAP_MIN = 11'd1100
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic        lcd_de,
  input  logic [15:0] lcd_rgb,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [10:0] pix_xpos,
  output logic [10:0] pix_ypos,
  output logic        frame_start,
  output logic        frame_done,
  output logic        locked,
  output logic [10:0] meas_hpos,
  output logic [10:0] meas_vpos,
  output logic        geom_err
);

  // state      | meaning
  // SEARCH     | counting DE-low run to find first vblank; no pixels
  // WAIT_FRAME | in vblank, waiting for first DE of the frame
  // LINE       | DE high, emitting pixels
  // HGAP       | DE low after a line; hblank or vblank decided by run length
  typedef enum logic [1:0] {SEARCH, WAIT_FRAME, LINE, HGAP} state_t;

  localparam logic [10:0] CNT_SAT = 11'h7ff;

  state_t      state, state_nxt;
  logic [10:0] x_cnt, x_nxt, y_cnt, y_nxt, gap_cnt, gap_nxt, line_w, line_w_nxt;
  logic [10:0] x_inc, y_inc, gap_inc;
  logic        err_q, err_nxt;
  logic        locked_q, locked_nxt;
  logic [10:0] meas_h_q, meas_h_nxt, meas_v_q, meas_v_nxt;

  logic        emit, emit_ok;
  logic [10:0] ex, ey;
  logic        start_pix;

  logic        p_valid, p_fs, p_fd, p_geom, p_geom_nxt, p_fd_nxt;
  logic [15:0] p_data;
  logic [10:0] p_x, p_y;

  assign x_inc   = (x_cnt == CNT_SAT) ? CNT_SAT : x_cnt + 11'd1;
  assign y_inc   = (y_cnt == CNT_SAT) ? CNT_SAT : y_cnt + 11'd1;
  assign gap_inc = (gap_cnt >= VGAP_MIN) ? VGAP_MIN : gap_cnt + 11'd1;

  always_comb begin
    state_nxt  = state;
    x_nxt      = x_cnt;
    y_nxt      = y_cnt;
    gap_nxt    = gap_cnt;
    line_w_nxt = line_w;
    err_nxt    = err_q;
    locked_nxt = locked_q;
    meas_h_nxt = meas_h_q;
    meas_v_nxt = meas_v_q;
    emit       = 1'b0;
    start_pix  = 1'b0;
    ex         = 11'd0;
    ey         = 11'd0;
    p_fd_nxt   = 1'b0;
    p_geom_nxt = 1'b0;

    case (state)
      SEARCH: begin
        if (lcd_de) begin
          gap_nxt = 11'd0;
        end else if (gap_inc >= VGAP_MIN) begin
          state_nxt  = WAIT_FRAME;
          locked_nxt = 1'b1;
          gap_nxt    = 11'd0;
        end else begin
          gap_nxt = gap_inc;
        end
      end
      WAIT_FRAME: begin
        if (lcd_de) begin
          state_nxt = LINE;
          emit      = 1'b1;
          start_pix = 1'b1;
          x_nxt     = 11'd1;
          y_nxt     = 11'd0;
          err_nxt   = 1'b0;
        end
      end
      LINE: begin
        if (lcd_de) begin
          emit  = 1'b1;
          ex    = x_cnt;
          ey    = y_cnt;
          x_nxt = x_inc;
        end else begin
          state_nxt  = HGAP;
          line_w_nxt = x_cnt;
          gap_nxt    = 11'd1;
          if (x_cnt != H_DISP) err_nxt = 1'b1;
        end
      end
      HGAP: begin
        if (lcd_de) begin
          state_nxt = LINE;
          emit      = 1'b1;
          ey        = y_inc;
          x_nxt     = 11'd1;
          y_nxt     = y_inc;
          gap_nxt   = 11'd0;
        end else if (gap_inc >= VGAP_MIN) begin
          state_nxt  = WAIT_FRAME;
          p_fd_nxt   = 1'b1;
          meas_h_nxt = line_w;
          meas_v_nxt = y_inc;
          gap_nxt    = 11'd0;
          x_nxt      = 11'd0;
          y_nxt      = 11'd0;
`ifdef CAP_GEOM_CHECK_EN
          p_geom_nxt = err_q | (y_inc != V_DISP);
`endif
        end else begin
          gap_nxt = gap_inc;
        end
      end
      default: state_nxt = SEARCH;
    endcase

`ifdef CAP_GEOM_CHECK_EN
    emit_ok = emit && (ex != CNT_SAT) && (ey != CNT_SAT) && (ex < H_DISP) && (ey < V_DISP);
`else
    emit_ok = emit && (ex != CNT_SAT) && (ey != CNT_SAT);
`endif
  end

  // FSM and first pipeline stage; the output stage below gives the one-cycle latency.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      state    <= SEARCH;
      x_cnt    <= 11'd0;
      y_cnt    <= 11'd0;
      gap_cnt  <= 11'd0;
      line_w   <= 11'd0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      meas_h_q <= 11'd0;
      meas_v_q <= 11'd0;
      p_valid  <= 1'b0;
      p_data   <= 16'd0;
      p_x      <= 11'd0;
      p_y      <= 11'd0;
      p_fs     <= 1'b0;
      p_fd     <= 1'b0;
      p_geom   <= 1'b0;
    end else begin
      state    <= state_nxt;
      x_cnt    <= x_nxt;
      y_cnt    <= y_nxt;
      gap_cnt  <= gap_nxt;
      line_w   <= line_w_nxt;
      err_q    <= err_nxt;
      locked_q <= locked_nxt;
      meas_h_q <= meas_h_nxt;
      meas_v_q <= meas_v_nxt;
      p_valid  <= emit_ok;
      p_data   <= emit_ok ? lcd_rgb : 16'd0;
      p_x      <= emit_ok ? ex : 11'd0;
      p_y      <= emit_ok ? ey : 11'd0;
      p_fs     <= emit_ok && start_pix;
      p_fd     <= p_fd_nxt;
      p_geom   <= p_geom_nxt;
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_data    <= 16'd0;
      pix_xpos    <= 11'd0;
      pix_ypos    <= 11'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      geom_err    <= 1'b0;
      locked      <= 1'b0;
      meas_hpos   <= 11'd0;
      meas_vpos   <= 11'd0;
    end else begin
      pix_valid   <= p_valid;
      pix_data    <= p_data;
      pix_xpos    <= p_x;
      pix_ypos    <= p_y;
      frame_start <= p_fs;
      frame_done  <= p_fd;
      geom_err    <= p_geom;
      locked      <= locked_q;
      meas_hpos   <= meas_h_q;
      meas_vpos   <= meas_v_q;
    end
  end

endmodule

// File: tb/tb_rgb_de_capture.sv
// Scoreboard bench for rgb_de_capture on a reduced 8x4 geometry with a 20-cycle vblank threshold.
module tb_rgb_de_capture;
  localparam logic [10:0] H = 11'd8;
  localparam logic [10:0] V = 11'd4;
  localparam logic [10:0] G = 11'd20;
  localparam int HG = 12;
`ifdef CAP_GEOM_CHECK_EN
  localparam bit GEOM = 1'b1;
`else
  localparam bit GEOM = 1'b0;
`endif

  logic        lcd_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        lcd_de = 1'b0;
  logic [15:0] lcd_rgb = 16'd0;
  logic        pix_valid, frame_start, frame_done, locked, geom_err;
  logic [15:0] pix_data;
  logic [10:0] pix_xpos, pix_ypos, meas_hpos, meas_vpos;

  rgb_de_capture #(.H_DISP(H), .V_DISP(V), .VGAP_MIN(G)) dut (
    .lcd_pclk(lcd_pclk), .rst(rst), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_xpos(pix_xpos), .pix_ypos(pix_ypos),
    .frame_start(frame_start), .frame_done(frame_done), .locked(locked),
    .meas_hpos(meas_hpos), .meas_vpos(meas_vpos), .geom_err(geom_err)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  typedef struct packed {logic [15:0] d; logic [10:0] x; logic [10:0] y; logic fs;} pix_t;
  typedef struct packed {logic [10:0] h; logic [10:0] v; logic g;} fd_t;

  pix_t exp_q[$];
  fd_t  fd_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   last_pushed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge lcd_pclk) begin : monitor
    pix_t e;
    fd_t  f;
    if (mon_en) begin
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d expected no pixel", pix_xpos, pix_ypos);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {pix_data, pix_xpos, pix_ypos, frame_start}, e);
        end
      end else begin
        check("idle_zero", {pix_data, pix_xpos, pix_ypos, frame_start}, 0);
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame_done: got pulse expected none");
        end else begin
          f = fd_q.pop_front();
          check("frame_done", {meas_hpos, meas_vpos, geom_err}, f);
        end
      end else begin
        check("geom_idle", geom_err, 0);
      end
    end
  end

  task automatic step(input logic de, input logic [15:0] rgb);
    lcd_de  = de;
    lcd_rgb = rgb;
    @(posedge lcd_pclk);
    #1;
  endtask

  task automatic low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'hdead);
    last_pushed = 1'b0;
  endtask

  task automatic pix_line(input int n, input int y, input bit first, input bit en);
    logic [15:0] d;
    bit push;
    for (int i = 0; i < n; i++) begin
      d = 16'(i) ^ {5'(y), 11'd0} ^ 16'h1234;
      push = en && (i < 2047) && (y < 2047) && (!GEOM || (i < int'(H) && y < int'(V)));
      if (push) exp_q.push_back({d, 11'(i), 11'(y), first && (i == 0)});
      last_pushed = push;
      step(1'b1, d);
    end
  endtask

  task automatic do_reset(input int n);
    // the pixel sampled just before the reset edge never reaches the outputs
    if (last_pushed) void'(exp_q.pop_back());
    last_pushed = 1'b0;
    rst = 1'b1;
    step(1'b1, 16'hffff);
    check("rst_pix", {pix_valid, pix_data, pix_xpos, pix_ypos, frame_start, frame_done, geom_err}, 0);
    check("rst_locked", locked, 0);
    check("rst_meas", {meas_hpos, meas_vpos}, 0);
    for (int i = 1; i < n; i++) step(1'b1, 16'hffff);
    rst = 1'b0;
  endtask

  task automatic run_frame(input int nl, input int wn, input int short_y, input int long_gap_y);
    int w;
    int lw;
    bit err;
    lw = 0;
    err = 1'b0;
    for (int y = 0; y < nl; y++) begin
      w = (y == short_y) ? wn - 1 : wn;
      pix_line(w, y, y == 0, 1'b1);
      lw = (w > 2047) ? 2047 : w;
      if (w != int'(H)) err = 1'b1;
      if (y < nl - 1) low((y == long_gap_y) ? int'(G) - 1 : HG);
    end
    if (nl != int'(V)) err = 1'b1;
    fd_q.push_back({11'(lw), 11'(nl), GEOM && err});
    low(int'(G));
  endtask

  initial begin
    do_reset(2);
    mon_en = 1'b1;

    // search: DE-high clears the run, a 19-cycle low run is not vblank
    pix_line(5, 0, 1'b0, 1'b0);
    low(int'(G) - 1);
    pix_line(5, 0, 1'b0, 1'b0);
    check("locked_early", locked, 0);
    low(int'(G));

    run_frame(4, 8, -1, 1);
    check("locked_after_frame", locked, 1);
    run_frame(4, 8, 1, -1);
    run_frame(5, 9, -1, -1);

    // reset mid-line, then pixels stay suppressed until a full vblank run
    pix_line(3, 0, 1'b1, 1'b1);
    do_reset(1);
    pix_line(4, 0, 1'b0, 1'b0);
    low(int'(G) - 1);
    pix_line(2, 0, 1'b0, 1'b0);
    check("locked_after_rst", locked, 0);
    low(int'(G));
    run_frame(4, 8, -1, -1);

    run_frame(1, 3000, -1, -1);
    check("locked_hold", locked, 1);

    low(4);
    check("pix_q_empty", exp_q.size(), 0);
    check("fd_q_empty", fd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
